initial_selection: RTL and testbench

INITIAL_SELECTION -- requirements
Module: initial_selection

---
 rtl/initial_selection.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_initial_selection.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/initial_selection.sv
// initial_selection -- control-unit side of a channel initial selection sequence.
// The unit answers a selection for its ADDRESS, echoes the address, latches
// the command byte for the host, presents the host's ending status and
// releases the interface. Optional build macro PARITY_CHECK_EN adds an odd
// parity check on the command byte, which forces a unit-check status (8'h02)
// and raises a sticky parity_error.
module initial_selection #(
  parameter logic [7:0] ADDRESS      = 8'h00,
  parameter bit         STACK_STATUS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  // channel side, driven by the device ahead on the chain
  input  logic [7:0] bus_out,
  input  logic       bus_out_parity,
  input  logic       operational_out,
  input  logic       address_out,
  input  logic       command_out,
  input  logic       service_out,
  input  logic       suppress_out,
  input  logic       selection_x,
  // channel side, returned towards the channel
  output logic [7:0] bus_in,
  output logic       bus_in_parity,
  output logic       operational_in,
  output logic       address_in,
  output logic       status_in,
  output logic       service_in,
  output logic       request_in,
  output logic       selection_y,
  // host side
  output logic [7:0] cmd,
  output logic       cmd_valid,
  input  logic [7:0] status,
  input  logic       status_valid,
  output logic       parity_error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELECTED  = 3'd1,
    ADDR_IN   = 3'd2,
    CMD_WAIT  = 3'd3,
    HOST_WAIT = 3'd4,
    STATUS_IN = 3'd5,
    RELEASE   = 3'd6
  } state_t;

  // Odd parity bit: makes the total number of ones over data plus bit odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  state_t     state_q, state_d;
  logic       sel_y_q, sel_y_d;
  logic       op_in_q, op_in_d;
  logic       addr_in_q, addr_in_d;
  logic       status_in_q, status_in_d;
  logic [7:0] bus_in_q, bus_in_d;
  logic       bus_in_par_q, bus_in_par_d;
  logic [7:0] cmd_q, cmd_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] status_q, status_d;
  logic       stacked_q, stacked_d;
  logic       service_in_q;
  logic       request_in_q;

  logic       sel_match_s;
  logic       cmd_capture_s;
  logic       unit_check_s;
  logic [7:0] presented_s;
  logic       unused_s;

  assign sel_match_s = operational_out && address_out && selection_x && (bus_out == ADDRESS);
  assign presented_s = unit_check_s ? 8'h02 : status;

  // Next state and next value of every registered output
  always_comb begin
    state_d       = state_q;
    sel_y_d       = 1'b0;
    op_in_d       = op_in_q;
    addr_in_d     = addr_in_q;
    status_in_d   = status_in_q;
    bus_in_d      = bus_in_q;
    bus_in_par_d  = bus_in_par_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = 1'b0;
    status_d      = status_q;
    stacked_d     = stacked_q;
    cmd_capture_s = 1'b0;
    if ((state_q != IDLE) && !operational_out) begin
      // system reset from the channel: drop everything, forget host status
      state_d      = IDLE;
      op_in_d      = 1'b0;
      addr_in_d    = 1'b0;
      status_in_d  = 1'b0;
      bus_in_d     = 8'h00;
      bus_in_par_d = 1'b0;
      status_d     = 8'h00;
      stacked_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_match_s) begin
            state_d = SELECTED;
            op_in_d = 1'b1;
            sel_y_d = 1'b0;
          end else begin
            sel_y_d = selection_x;
          end
        end
        SELECTED: begin
          if (!address_out) begin
            state_d      = ADDR_IN;
            addr_in_d    = 1'b1;
            bus_in_d     = ADDRESS;
            bus_in_par_d = odd_parity(ADDRESS);
          end else begin
            state_d = SELECTED;
          end
        end
        ADDR_IN: begin
          if (command_out) begin
            state_d       = CMD_WAIT;
            cmd_d         = bus_out;
            cmd_valid_d   = 1'b1;
            cmd_capture_s = 1'b1;
            addr_in_d     = 1'b0;
            bus_in_d      = 8'h00;
            bus_in_par_d  = 1'b0;
          end else begin
            state_d = ADDR_IN;
          end
        end
        CMD_WAIT: begin
          if (!command_out) begin
            state_d = HOST_WAIT;
          end else begin
            state_d = CMD_WAIT;
          end
        end
        HOST_WAIT: begin
          if (status_valid) begin
            state_d      = STATUS_IN;
            status_d     = presented_s;
            stacked_d    = 1'b0;
            status_in_d  = 1'b1;
            bus_in_d     = presented_s;
            bus_in_par_d = odd_parity(presented_s);
          end else begin
            state_d = HOST_WAIT;
          end
        end
        STATUS_IN: begin
          if (stacked_q) begin
            // stacked: status withdrawn until command_out falls, then re-presented
            if (!command_out) begin
              stacked_d    = 1'b0;
              status_in_d  = 1'b1;
              bus_in_d     = status_q;
              bus_in_par_d = odd_parity(status_q);
            end else begin
              stacked_d = 1'b1;
            end
          end else if (service_out) begin
            // accept wins even when command_out is also up
            state_d      = RELEASE;
            status_in_d  = 1'b0;
            bus_in_d     = 8'h00;
            bus_in_par_d = 1'b0;
          end else if (command_out) begin
            status_in_d  = 1'b0;
            bus_in_d     = 8'h00;
            bus_in_par_d = 1'b0;
            if (STACK_STATUS) begin
              stacked_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            state_d = STATUS_IN;
          end
        end
        RELEASE: begin
          if (!service_out && !command_out) begin
            state_d = IDLE;
            op_in_d = 1'b0;
          end else begin
            state_d = RELEASE;
          end
        end
        default: begin
          state_d      = IDLE;
          op_in_d      = 1'b0;
          addr_in_d    = 1'b0;
          status_in_d  = 1'b0;
          bus_in_d     = 8'h00;
          bus_in_par_d = 1'b0;
          stacked_d    = 1'b0;
        end
      endcase
    end
  end

  // Selection FSM state and registered channel/host outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_y_q      <= 1'b0;
      op_in_q      <= 1'b0;
      addr_in_q    <= 1'b0;
      status_in_q  <= 1'b0;
      bus_in_q     <= 8'h00;
      bus_in_par_q <= 1'b0;
      cmd_q        <= 8'h00;
      cmd_valid_q  <= 1'b0;
      status_q     <= 8'h00;
      stacked_q    <= 1'b0;
      service_in_q <= 1'b0;
      request_in_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_y_q      <= sel_y_d;
      op_in_q      <= op_in_d;
      addr_in_q    <= addr_in_d;
      status_in_q  <= status_in_d;
      bus_in_q     <= bus_in_d;
      bus_in_par_q <= bus_in_par_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      status_q     <= status_d;
      stacked_q    <= stacked_d;
      // data transfer and request-in are not handled by this unit
      service_in_q <= 1'b0;
      request_in_q <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  logic parity_fail_s;
  logic perr_q, perr_d;
  logic unit_check_q, unit_check_d;

  assign parity_fail_s = cmd_capture_s && (bus_out_parity != odd_parity(bus_out));
  assign unit_check_s  = unit_check_q;
  assign parity_error  = perr_q;
  assign unused_s      = suppress_out;

  // Sticky parity error and per-transaction unit-check request
  always_comb begin
    perr_d       = perr_q | parity_fail_s;
    unit_check_d = unit_check_q;
    if (parity_fail_s) begin
      unit_check_d = 1'b1;
    end else if (cmd_capture_s) begin
      unit_check_d = 1'b0;
    end else begin
      unit_check_d = unit_check_q;
    end
  end

  // Parity check registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q       <= 1'b0;
      unit_check_q <= 1'b0;
    end else begin
      perr_q       <= perr_d;
      unit_check_q <= unit_check_d;
    end
  end
`else
  assign unit_check_s = 1'b0;
  assign parity_error = 1'b0;
  assign unused_s     = suppress_out ^ bus_out_parity ^ cmd_capture_s;
`endif

  assign bus_in         = bus_in_q;
  assign bus_in_parity  = bus_in_par_q;
  assign operational_in = op_in_q;
  assign address_in     = addr_in_q;
  assign status_in      = status_in_q;
  assign service_in     = service_in_q;
  assign request_in     = request_in_q;
  assign selection_y    = sel_y_q;
  assign cmd            = cmd_q;
  assign cmd_valid      = cmd_valid_q;

endmodule

// File: tb/tb_initial_selection.sv
// tb_initial_selection -- directed stimulus, a transaction-level reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_initial_selection;

  localparam logic [7:0] ADDR = 8'h42;
`ifdef PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  localparam int P_IDLE = 0, P_SEL = 1, P_ADDR_IN = 2, P_CMD_WAIT = 3,
                 P_HOST = 4, P_STATUS_IN = 5, P_RELEASE = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] bus_out = 8'h00;
  logic       bus_out_parity = 1'b0;
  logic       operational_out = 1'b0;
  logic       address_out = 1'b0;
  logic       command_out = 1'b0;
  logic       service_out = 1'b0;
  logic       suppress_out = 1'b0;
  logic       selection_x = 1'b0;
  logic [7:0] status = 8'h00;
  logic       status_valid = 1'b0;

  logic [7:0] bus_in;
  logic       bus_in_parity, operational_in, address_in, status_in;
  logic       service_in, request_in, selection_y;
  logic [7:0] cmd;
  logic       cmd_valid, parity_error;

  int checks = 0;
  int failures = 0;

  // model state
  int         m_phase = P_IDLE;
  int         m_prev = P_IDLE;
  bit         m_in_reset = 1'b1;
  bit         m_selx = 1'b0;
  bit         m_stacked = 1'b0;
  bit         m_cmdv = 1'b0;
  bit         m_perr = 1'b0;
  bit         m_uc = 1'b0;
  logic [7:0] m_status = 8'h00;
  logic [7:0] m_cmd = 8'h00;

  always #5 clk = ~clk;

  initial_selection #(.ADDRESS(ADDR), .STACK_STATUS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .bus_out(bus_out), .bus_out_parity(bus_out_parity),
    .operational_out(operational_out), .address_out(address_out),
    .command_out(command_out), .service_out(service_out),
    .suppress_out(suppress_out), .selection_x(selection_x),
    .bus_in(bus_in), .bus_in_parity(bus_in_parity),
    .operational_in(operational_in), .address_in(address_in),
    .status_in(status_in), .service_in(service_in),
    .request_in(request_in), .selection_y(selection_y),
    .cmd(cmd), .cmd_valid(cmd_valid),
    .status(status), .status_valid(status_valid),
    .parity_error(parity_error)
  );

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the transaction model by one clock using the inputs at the edge
  task automatic model_step();
    m_cmdv = 1'b0;
    if (reset) begin
      m_in_reset = 1'b1;
      m_phase = P_IDLE; m_prev = P_IDLE; m_selx = 1'b0;
      m_stacked = 1'b0; m_perr = 1'b0; m_uc = 1'b0;
      m_status = 8'h00; m_cmd = 8'h00;
    end else begin
      m_in_reset = 1'b0;
      m_prev = m_phase;
      m_selx = selection_x;
      if (m_phase != P_IDLE && !operational_out) begin
        m_phase = P_IDLE; m_stacked = 1'b0;
      end else begin
        case (m_phase)
          P_IDLE: if (operational_out && address_out && selection_x && bus_out == ADDR) m_phase = P_SEL;
          P_SEL: if (!address_out) m_phase = P_ADDR_IN;
          P_ADDR_IN: if (command_out) begin
            m_cmd = bus_out; m_cmdv = 1'b1;
            m_uc = PCHK && (($countones({bus_out, bus_out_parity}) % 2) == 0);
            if (m_uc) m_perr = 1'b1;
            m_phase = P_CMD_WAIT;
          end
          P_CMD_WAIT: if (!command_out) m_phase = P_HOST;
          P_HOST: if (status_valid) begin
            m_status = m_uc ? 8'h02 : status; m_stacked = 1'b0; m_phase = P_STATUS_IN;
          end
          P_STATUS_IN: begin
            if (m_stacked) begin
              if (!command_out) m_stacked = 1'b0;
            end else if (service_out) m_phase = P_RELEASE;
            else if (command_out) m_stacked = 1'b1;
          end
          P_RELEASE: if (!service_out && !command_out) m_phase = P_IDLE;
          default: m_phase = P_IDLE;
        endcase
      end
    end
  endtask

  // Compare every DUT output against what the model says it must be
  task automatic compare();
    logic       e_addr, e_stat, e_par, e_sely;
    logic [7:0] e_bus;
    e_addr = (m_phase == P_ADDR_IN);
    e_stat = (m_phase == P_STATUS_IN) && !m_stacked;
    e_bus  = e_addr ? ADDR : (e_stat ? m_status : 8'h00);
    e_par  = (e_addr || e_stat) ? (($countones(e_bus) % 2) == 0) : 1'b0;
    e_sely = (!m_in_reset && m_phase == P_IDLE && m_prev == P_IDLE) ? m_selx : 1'b0;
    chk1("m_selection_y", selection_y, e_sely);
    chk1("m_operational_in", operational_in, m_phase != P_IDLE);
    chk1("m_address_in", address_in, e_addr);
    chk1("m_status_in", status_in, e_stat);
    chk8("m_bus_in", bus_in, e_bus);
    chk1("m_bus_in_parity", bus_in_parity, e_par);
    chk1("m_service_in", service_in, 1'b0);
    chk1("m_request_in", request_in, 1'b0);
    chk8("m_cmd", cmd, m_cmd);
    chk1("m_cmd_valid", cmd_valid, m_cmdv);
    chk1("m_parity_error", parity_error, m_perr);
  endtask

  // Model update at each edge and output comparison just after it
  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic select_dev();
    bus_out = ADDR; address_out = 1'b1; selection_x = 1'b1;
    cyc();
    bus_out = 8'h00; address_out = 1'b0; selection_x = 1'b0;
    cyc();
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic p);
    bus_out = b; bus_out_parity = p; command_out = 1'b1;
    cyc();
    bus_out = 8'h00; bus_out_parity = 1'b0; command_out = 1'b0;
    cyc();
  endtask

  task automatic host_status(input logic [7:0] s);
    status = s; status_valid = 1'b1;
    cyc();
    status = 8'h00; status_valid = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk1("rst_operational_in", operational_in, 1'b0);
    chk1("rst_selection_y", selection_y, 1'b0);
    chk8("rst_bus_in", bus_in, 8'h00);
    chk1("rst_cmd_valid", cmd_valid, 1'b0);
    chk1("rst_parity_error", parity_error, 1'b0);
    cyc();
    reset = 1'b0; operational_out = 1'b1; selection_x = 1'b1;
    cyc();
    chk1("resume_selection_y", selection_y, 1'b1);

    // no address match: selection propagates, unit stays idle
    bus_out = 8'h43; address_out = 1'b1; selection_x = 1'b1;
    cyc();
    chk1("nomatch_selection_y", selection_y, 1'b1);
    chk1("nomatch_operational_in", operational_in, 1'b0);
    bus_out = 8'h00; address_out = 1'b0; selection_x = 1'b0;
    cyc();
    chk1("nomatch_sel_y_fall", selection_y, 1'b0);

    // full sequence with a stacked status
    bus_out = ADDR; address_out = 1'b1; selection_x = 1'b1;
    cyc();
    chk1("sel_operational_in", operational_in, 1'b1);
    chk1("sel_selection_y", selection_y, 1'b0);
    cyc();
    chk1("sel_wait_address_in", address_in, 1'b0);
    bus_out = 8'h00; address_out = 1'b0; selection_x = 1'b0;
    cyc();
    chk1("ain_address_in", address_in, 1'b1);
    chk8("ain_bus_in", bus_in, 8'h42);
    chk1("ain_parity", bus_in_parity, 1'b1);
    address_out = 1'b1;
    cyc();
    chk1("reselect_ignored", address_in, 1'b1);
    address_out = 1'b0; status = 8'hAA; status_valid = 1'b1;
    cyc();
    chk1("early_status_ignored", status_in, 1'b0);
    status = 8'h00; status_valid = 1'b0;
    bus_out = 8'h01; bus_out_parity = 1'b0; command_out = 1'b1;
    cyc();
    chk8("cmd_byte", cmd, 8'h01);
    chk1("cmd_valid_pulse", cmd_valid, 1'b1);
    chk1("cmd_address_in_drop", address_in, 1'b0);
    chk8("cmd_bus_in_drop", bus_in, 8'h00);
    cyc();
    chk1("cmd_valid_one_cycle", cmd_valid, 1'b0);
    command_out = 1'b0; bus_out = 8'h00;
    cyc();
    host_status(8'h0C);
    chk1("st_status_in", status_in, 1'b1);
    chk8("st_bus_in", bus_in, 8'h0C);
    chk1("st_parity", bus_in_parity, 1'b1);
    command_out = 1'b1;
    cyc();
    chk1("stack_drop", status_in, 1'b0);
    cyc();
    command_out = 1'b0;
    cyc();
    chk1("stack_represent", status_in, 1'b1);
    chk8("stack_bus_in", bus_in, 8'h0C);
    service_out = 1'b1; command_out = 1'b1;
    cyc();
    chk1("both_accept_drop", status_in, 1'b0);
    command_out = 1'b0;
    cyc();
    chk1("both_accept_no_represent", status_in, 1'b0);
    chk1("release_hold_op_in", operational_in, 1'b1);
    service_out = 1'b0;
    cyc();
    chk1("release_op_in", operational_in, 1'b0);
    selection_x = 1'b1;
    cyc();
    chk1("post_release_sel_y", selection_y, 1'b1);
    selection_x = 1'b0;
    cyc();

    // system reset from the channel during status presentation
    select_dev();
    send_cmd(8'h03, 1'b1);
    host_status(8'h0C);
    operational_out = 1'b0;
    cyc();
    chk1("abort_op_in", operational_in, 1'b0);
    chk1("abort_status_in", status_in, 1'b0);
    chk8("abort_bus_in", bus_in, 8'h00);
    operational_out = 1'b1; status = 8'h55; status_valid = 1'b1;
    cyc();
    status = 8'h00; status_valid = 1'b0;
    select_dev();
    chk1("reselect_address_in", address_in, 1'b1);
    send_cmd(8'h04, 1'b0);
    chk1("no_stale_status", status_in, 1'b0);
    host_status(8'h30);
    chk8("fresh_status", bus_in, 8'h30);
    service_out = 1'b1;
    cyc();
    service_out = 1'b0;
    cyc();

    // command byte with even parity
    select_dev();
    bus_out = 8'h05; bus_out_parity = 1'b0; command_out = 1'b1;
    cyc();
    chk1("perr_flag", parity_error, PCHK);
    chk1("perr_cmd_valid", cmd_valid, 1'b1);
    bus_out = 8'h00; command_out = 1'b0;
    cyc();
    host_status(8'h0C);
    chk8("perr_status", bus_in, PCHK ? 8'h02 : 8'h0C);
    chk1("perr_status_parity", bus_in_parity, !PCHK);
    service_out = 1'b1;
    cyc();
    service_out = 1'b0;
    cyc();
    chk1("perr_sticky", parity_error, PCHK);
    select_dev();
    send_cmd(8'h01, 1'b0);
    host_status(8'h0C);
    chk8("good_parity_status", bus_in, 8'h0C);
    service_out = 1'b1;
    cyc();
    service_out = 1'b0;
    cyc();

    // asynchronous reset in mid-transaction
    select_dev();
    reset = 1'b1;
    #1;
    chk1("async_rst_op_in", operational_in, 1'b0);
    chk1("async_rst_address_in", address_in, 1'b0);
    chk8("async_rst_bus_in", bus_in, 8'h00);
    chk1("async_rst_parity_error", parity_error, 1'b0);
    cyc();
    reset = 1'b0; selection_x = 1'b1;
    cyc();
    chk1("async_rst_resume", selection_y, 1'b1);
    selection_x = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
